pc_fetch_ctrl: RTL and testbench

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

---
 rtl/pc_fetch_ctrl.sv | 133 +++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: IF-stage PC generation for a single-issue pipeline with a
// branch delay slot. Computes the next fetch address, drives the synchronous
// instruction SRAM, parks redirects that arrive while IF is stalled, and
// buffers the fetched instruction so ID sees a stable value across stalls.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_valid,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] br_target,
    input  logic [31:0] jr_target,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid,
    output logic        redirect_pending,
    output logic        addr_err
);

    localparam logic [1:0] BOOT = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] PEND = 2'd2;

    // pc_q starts one word before the vector so the first sequential step lands on it
    localparam logic [31:0] PC_RST = RESET_VEC - 32'd4;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q;
    logic        valid_q;
    logic        err_q;
    logic [31:0] pend_tgt_q;
    logic        pend_err_q;
    logic [31:0] hold_q;
    logic        hold_act_q;

    logic        redir;
    logic [31:0] redir_tgt;
    logic [31:0] nxt;
    logic        nxt_err;
    logic [31:0] nxt_al;
    logic        capture;

    // Redirect decode; codes 0 and 3 both mean fall-through
    always_comb begin
        redir     = br_valid && (pc_sel == 2'd1 || pc_sel == 2'd2);
        redir_tgt = (pc_sel == 2'd2) ? jr_target : br_target;
    end

    // Next fetch address: parked target beats a live redirect beats pc+4
    always_comb begin
        nxt     = pc_q + 32'd4;
        nxt_err = 1'b0;
        if (state_q == PEND) begin
            nxt     = pend_tgt_q;
            nxt_err = pend_err_q;
        end else if (redir) begin
            nxt     = redir_tgt;
            nxt_err = |redir_tgt[1:0];
        end
        nxt_al  = {nxt[31:2], 2'b00};
        capture = stall && (state_q == RUN) && redir;
    end

    // State transitions; any advance lands in RUN, the spare code self-heals to RUN
    always_comb begin
        state_d = state_q;
        if (!stall)
            state_d = RUN;
        else if (capture)
            state_d = PEND;
        else if (state_q == 2'b11)
            state_d = RUN;
    end

    // State and PC / qualifier registers; PC and valid only move when IF advances
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= PC_RST;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (!stall) begin
                pc_q    <= nxt_al;
                valid_q <= 1'b1;
                err_q   <= nxt_err;
            end
        end
    end

    // Park a redirect that arrives during a stall until IF can advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_tgt_q <= 32'd0;
            pend_err_q <= 1'b0;
        end else if (capture) begin
            pend_tgt_q <= {redir_tgt[31:2], 2'b00};
            pend_err_q <= |redir_tgt[1:0];
        end
    end

    // SRAM data is only valid the cycle after a read, so grab it on the first stalled edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q     <= 32'd0;
            hold_act_q <= 1'b0;
        end else if (stall) begin
            if (!hold_act_q)
                hold_q <= inst_sram_rdata;
            hold_act_q <= 1'b1;
        end else begin
            hold_act_q <= 1'b0;
        end
    end

    // Output drive
    always_comb begin
        inst_sram_en     = ~stall;
        inst_sram_addr   = nxt_al;
        if_pc            = pc_q;
        if_inst          = hold_act_q ? hold_q : inst_sram_rdata;
        if_valid         = valid_q;
        redirect_pending = (state_q == PEND);
        addr_err         = err_q;
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl. A behavioural SRAM returns a unique word
// per address (random junk when not enabled, so the hold buffer matters).
// Each issued fetch pushes its expected PC/addr_err into a queue; the entry
// is popped and compared once the fetch lands on if_pc.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        br_valid;
    logic [1:0]  pc_sel;
    logic [31:0] br_target;
    logic [31:0] jr_target;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata = 32'd0;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        redirect_pending;
    logic        addr_err;

    typedef struct {
        logic [31:0] pc;
        logic        err;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    int          n_assert = 0;
    int          n_fail   = 0;

    pc_fetch_ctrl #(.RESET_VEC(32'hBFC00000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .br_valid(br_valid), .pc_sel(pc_sel),
        .br_target(br_target), .jr_target(jr_target),
        .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr),
        .inst_sram_rdata(inst_sram_rdata),
        .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid),
        .redirect_pending(redirect_pending), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1234_5678;
    endfunction

    always @(posedge clk)
        inst_sram_rdata <= inst_sram_en ? inst_of(inst_sram_addr) : $urandom();

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: check the combinational fetch request, then the
    // IF outputs after the edge (new fetch if advancing, frozen if stalled).
    task automatic cyc(input logic st, input logic brv, input logic [1:0] sel,
                       input logic [31:0] bt, input logic [31:0] jt,
                       input logic [31:0] ea, input logic ee);
        exp_t e;
        stall = st; br_valid = brv; pc_sel = sel; br_target = bt; jr_target = jt;
        #1;
        chk("sram_addr", inst_sram_addr, ea);
        chk("sram_en", {31'd0, inst_sram_en}, {31'd0, ~st});
        if (!st) begin
            e.pc = ea; e.err = ee;
            q.push_back(e);
        end
        @(posedge clk); #1;
        if (!st) begin
            if (q.size() == 0) begin
                chk("queue_underflow", 32'd1, 32'd0);
            end else begin
                cur = q.pop_front();
            end
            chk("if_valid", {31'd0, if_valid}, 32'd1);
        end
        chk(st ? "frozen_pc" : "if_pc", if_pc, cur.pc);
        chk(st ? "frozen_inst" : "if_inst", if_inst, inst_of(cur.pc));
        chk("addr_err", {31'd0, addr_err}, {31'd0, cur.err});
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; br_valid = 1'b0; pc_sel = 2'd0;
        br_target = 32'd0; jr_target = 32'd0;
        cur.pc = 32'd0; cur.err = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_pending", {31'd0, redirect_pending}, 32'd0);
        chk("rst_addr_err", {31'd0, addr_err}, 32'd0);
        chk("rst_if_pc", if_pc, 32'hBFBFFFFC);
        chk("rst_if_inst", if_inst, inst_sram_rdata);
        rst = 1'b0;
        #1;
        chk("rel_if_valid", {31'd0, if_valid}, 32'd0);

        // Sequential fetch from the reset vector
        cyc(0, 0, 0, 0, 0, 32'hBFC00000, 0);
        cyc(0, 0, 0, 0, 0, 32'hBFC00004, 0);
        cyc(0, 0, 0, 0, 0, 32'hBFC00008, 0);
        cyc(0, 0, 0, 0, 0, 32'hBFC0000C, 0);
        cyc(0, 0, 0, 0, 0, 32'hBFC00010, 0);

        // Taken branch; delay slot at BFC00010 is in IF in the branch cycle
        chk("delay_slot_pc", if_pc, 32'hBFC00010);
        chk("delay_slot_inst", if_inst, inst_of(32'hBFC00010));
        cyc(0, 1, 1, 32'h80001000, 0, 32'h80001000, 0);
        cyc(0, 0, 0, 0, 0, 32'h80001004, 0);

        // Register jump taken during a 3-cycle stall; later branches ignored
        chk("pend_before", {31'd0, redirect_pending}, 32'd0);
        cyc(1, 1, 2, 0, 32'h80002000, 32'h80002000, 0);
        chk("pend_1", {31'd0, redirect_pending}, 32'd1);
        cyc(1, 1, 1, 32'hDEAD0000, 0, 32'h80002000, 0);
        chk("pend_2", {31'd0, redirect_pending}, 32'd1);
        cyc(1, 1, 1, 32'hDEAD0000, 0, 32'h80002000, 0);
        chk("pend_3", {31'd0, redirect_pending}, 32'd1);
        cyc(0, 0, 0, 0, 0, 32'h80002000, 0);
        chk("pend_clear", {31'd0, redirect_pending}, 32'd0);
        cyc(0, 0, 0, 0, 0, 32'h80002004, 0);

        // Misaligned branch target: aligned fetch, addr_err for one instruction
        cyc(0, 1, 1, 32'h80003002, 0, 32'h80003000, 1);
        cyc(0, 0, 0, 0, 0, 32'h80003004, 0);

        // Misaligned register target parked during stall
        cyc(1, 1, 2, 0, 32'h80005001, 32'h80005000, 0);
        cyc(0, 0, 0, 0, 0, 32'h80005000, 1);
        cyc(0, 0, 0, 0, 0, 32'h80005004, 0);

        // Non-redirect decision codes
        cyc(0, 1, 3, 32'h90000000, 32'h90000000, 32'h80005008, 0);
        cyc(0, 1, 0, 32'h90000000, 32'h90000000, 32'h8000500C, 0);
        cyc(0, 0, 1, 32'h90000000, 32'h90000000, 32'h80005010, 0);
        cyc(0, 0, 2, 32'h90000000, 32'h90000000, 32'h80005014, 0);

        // 32-bit wrap of the sequential PC
        cyc(0, 1, 1, 32'hFFFFFFF8, 0, 32'hFFFFFFF8, 0);
        cyc(0, 0, 0, 0, 0, 32'hFFFFFFFC, 0);
        cyc(0, 0, 0, 0, 0, 32'h00000000, 0);
        cyc(0, 0, 0, 0, 0, 32'h00000004, 0);

        // Reset while a redirect is parked mid-stall
        cyc(1, 1, 1, 32'h80004000, 0, 32'h80004000, 0);
        chk("pend_pre_rst", {31'd0, redirect_pending}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_pending", {31'd0, redirect_pending}, 32'd0);
        chk("mid_rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("mid_rst_if_pc", if_pc, 32'hBFBFFFFC);
        chk("mid_rst_if_inst", if_inst, inst_sram_rdata);
        stall = 1'b0; br_valid = 1'b0; pc_sel = 2'd0;
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        cyc(0, 0, 0, 0, 0, 32'hBFC00000, 0);
        cyc(0, 0, 0, 0, 0, 32'hBFC00004, 0);
        cyc(0, 0, 0, 0, 0, 32'hBFC00008, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Absolute watchdog so the run always terminates
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
